// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NCORES requesters.
// One transaction at a time: latch, issue for one cycle, optional read wait, done pulse.
module mem_rr_arbiter #(
    parameter int NCORES = 3,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    we,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    input  logic [DW-1:0]        ram_q,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_din,
    output logic                 ram_wren,
    output logic [NCORES-1:0]    gnt,
    output logic [NCORES-1:0]    done,
    output logic [DW-1:0]        rdata,
    output logic                 busy
);

    localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n, cur, cur_n, win;
    logic [CW-1:0]   cnt, cnt_n;
    logic            lat_we, lat_we_n, found, last_wait;
    int unsigned     idx;

    logic [NCORES-1:0] gnt_n, done_n;
    logic [DW-1:0]     rdata_n, ram_din_n;
    logic [AW-1:0]     ram_addr_n;
    logic              ram_wren_n, busy_n;

    // First requester at or after ptr, wrapping modulo NCORES.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NCORES; k++) begin
            idx = (32'(ptr) + k) % NCORES;
            if (!found && req[PW'(idx)]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
    end

    assign last_wait = (cnt == CW'(RD_LAT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cur      <= '0;
            cnt      <= '0;
            lat_we   <= 1'b0;
            gnt      <= '0;
            done     <= '0;
            rdata    <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_wren <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cur      <= cur_n;
            cnt      <= cnt_n;
            lat_we   <= lat_we_n;
            gnt      <= gnt_n;
            done     <= done_n;
            rdata    <= rdata_n;
            ram_addr <= ram_addr_n;
            ram_din  <= ram_din_n;
            ram_wren <= ram_wren_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (found) state_n = ISSUE;
            ISSUE:   state_n = lat_we ? DONE : WAIT;
            WAIT:    if (last_wait) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered, so each value here is what the next state presents.
    always_comb begin
        ptr_n      = ptr;
        cur_n      = cur;
        cnt_n      = cnt;
        lat_we_n   = lat_we;
        gnt_n      = gnt;
        rdata_n    = rdata;
        ram_addr_n = ram_addr;
        ram_din_n  = ram_din;
        ram_wren_n = 1'b0;
        busy_n     = (state_n != IDLE);
        done_n     = (state_n == DONE) ? gnt : '0;
        case (state)
            IDLE: begin
                if (found) begin
                    cur_n      = win;
                    gnt_n      = NCORES'(1) << win;
                    lat_we_n   = we[win];
                    ram_addr_n = addr[int'(win)*AW +: AW];
                    ram_din_n  = wdata[int'(win)*DW +: DW];
                    ram_wren_n = we[win];
                end else begin
                    gnt_n = '0;
                end
            end
            ISSUE: cnt_n = '0;
            WAIT: begin
                cnt_n = cnt + 1'b1;
                if (last_wait) rdata_n = ram_q;
            end
            DONE: begin
                gnt_n = '0;
                ptr_n = (cur == PW'(NCORES - 1)) ? '0 : cur + 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a behavioural 256x8 synchronous RAM (read latency 1).
module tb_mem_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  we = '0;
    logic [23:0] addr = '0;
    logic [23:0] wdata = '0;
    logic [7:0]  ram_q = '0;
    logic [7:0]  ram_addr, ram_din, rdata;
    logic        ram_wren, busy;
    logic [2:0]  gnt, done;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic       mem_init = 1'b0;

    logic [2:0] rot_core [6];
    logic [7:0] rot_data [3];

    mem_rr_arbiter #(.NCORES(3), .AW(8), .DW(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ram_q(ram_q), .ram_addr(ram_addr), .ram_din(ram_din), .ram_wren(ram_wren),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM preloaded with i ^ 0x5A on its first edge; registered read, read-before-write.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem_init <= 1'b1;
        end else begin
            if (ram_wren) mem[ram_addr] <= ram_din;
            ram_q <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rot_core[0] = 3'b001; rot_core[1] = 3'b010; rot_core[2] = 3'b100;
        rot_core[3] = 3'b001; rot_core[4] = 3'b010; rot_core[5] = 3'b100;
        rot_data[0] = 8'h3C;  rot_data[1] = 8'h6A;  rot_data[2] = 8'h77;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wren", 32'(ram_wren), 0);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_rdata", 32'(rdata), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_gnt", 32'(gnt), 0);

        // Single write by core1; other cores' fields are junk and must be ignored
        req = 3'b010; we = 3'b111; addr = 24'h99_12_77; wdata = 24'hEE_A5_DD;
        @(negedge clk);
        check("w1_gnt", 32'(gnt), 32'h2);
        check("w1_addr", 32'(ram_addr), 32'h12);
        check("w1_din", 32'(ram_din), 32'hA5);
        check("w1_wren", 32'(ram_wren), 1);
        check("w1_done_early", 32'(done), 0);
        @(negedge clk);
        check("w1_done", 32'(done), 32'h2);
        check("w1_wren_off", 32'(ram_wren), 0);
        req = 3'b000; we = 3'b000;
        @(negedge clk);
        check("w1_idle_gnt", 32'(gnt), 0);
        check("w1_idle_done", 32'(done), 0);
        check("w1_idle_busy", 32'(busy), 0);
        check("w1_addr_hold", 32'(ram_addr), 32'h12);

        // Single read by core2 of 0x12 (now 0xA5)
        req = 3'b100; we = 3'b000; addr = 24'h12_00_00;
        @(negedge clk);
        check("r2_gnt", 32'(gnt), 32'h4);
        check("r2_wren_issue", 32'(ram_wren), 0);
        check("r2_addr", 32'(ram_addr), 32'h12);
        @(negedge clk);
        check("r2_done_wait", 32'(done), 0);
        check("r2_wren_wait", 32'(ram_wren), 0);
        check("r2_busy_wait", 32'(busy), 1);
        @(negedge clk);
        check("r2_done", 32'(done), 32'h4);
        check("r2_rdata", 32'(rdata), 32'hA5);
        check("r2_wren_done", 32'(ram_wren), 0);
        req = 3'b000;
        @(negedge clk);
        check("r2_rdata_hold", 32'(rdata), 32'hA5);
        check("r2_done_clear", 32'(done), 0);

        // Core0 write, req dropped during ISSUE; ptr 0 -> 1
        req = 3'b001; we = 3'b001; addr = 24'h00_00_20; wdata = 24'h00_00_3C;
        @(negedge clk);
        check("w0_gnt", 32'(gnt), 32'h1);
        check("w0_wren", 32'(ram_wren), 1);
        check("w0_addr", 32'(ram_addr), 32'h20);
        req = 3'b000; we = 3'b000; addr = '0; wdata = '0;
        @(negedge clk);
        check("w0_done", 32'(done), 32'h1);
        @(negedge clk);
        check("w0_idle_busy", 32'(busy), 0);
        check("w0_rdata_kept", 32'(rdata), 32'hA5);

        // Core0 read + core2 write together with ptr=1: core2 first
        req = 3'b101; we = 3'b100; addr = 24'h50_00_20; wdata = 24'h77_00_00;
        @(negedge clk);
        check("sim_gnt_c2", 32'(gnt), 32'h4);
        check("sim_wren_c2", 32'(ram_wren), 1);
        check("sim_din_c2", 32'(ram_din), 32'h77);
        @(negedge clk);
        check("sim_done_c2", 32'(done), 32'h4);
        req = 3'b001; we = 3'b000;
        @(negedge clk);
        check("sim_idle_gnt", 32'(gnt), 0);
        @(negedge clk);
        check("sim_gnt_c0", 32'(gnt), 32'h1);
        check("sim_addr_c0", 32'(ram_addr), 32'h20);
        @(negedge clk);
        @(negedge clk);
        check("sim_done_c0", 32'(done), 32'h1);
        check("sim_rdata_c0", 32'(rdata), 32'h3C);
        req = 3'b000;
        @(negedge clk);

        // Reset during WAIT of a core2 read (ptr is 1 here)
        req = 3'b100; addr = 24'h50_00_00;
        @(negedge clk);
        check("ab_gnt", 32'(gnt), 32'h4);
        @(negedge clk);
        rst = 1'b1; req = 3'b000;
        #1;
        check("ab_rst_gnt", 32'(gnt), 0);
        check("ab_rst_busy", 32'(busy), 0);
        check("ab_rst_wren", 32'(ram_wren), 0);
        check("ab_rst_done", 32'(done), 0);
        @(negedge clk);
        check("ab_rst_done2", 32'(done), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ab_post_done", 32'(done), 0);

        // Continuous reads by all cores: order 0,1,2,0,1,2 proves ptr was reset
        req = 3'b111; we = 3'b000; addr = 24'h50_30_20;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check($sformatf("rot%0d_gnt", n), 32'(gnt), 32'(rot_core[n]));
            @(negedge clk);
            check($sformatf("rot%0d_wait_done", n), 32'(done), 0);
            @(negedge clk);
            check($sformatf("rot%0d_done", n), 32'(done), 32'(rot_core[n]));
            check($sformatf("rot%0d_rdata", n), 32'(rdata), 32'(rot_data[n % 3]));
            if (n == 5) req = 3'b000;
            @(negedge clk);
            check($sformatf("rot%0d_idle_gnt", n), 32'(gnt), 0);
        end
        @(negedge clk);
        check("end_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
